// File: rtl/arith_seq_pkg.sv
// ----------------------------------------------------------------------------
// arith_seq_pkg
// Shared definitions for the sequential arithmetic units (shift-add multiplier
// and restoring divider).
//   - FSM state encoding used by both units
//   - start/done handshake polarity constants
//   - small helpers for decoding the FSM state
// No ports: this is a package.
// ----------------------------------------------------------------------------
package arith_seq_pkg;

  // Common three-state controller: wait for start, iterate, report result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake polarities shared with the multiplier.
  localparam logic START_ASSERTED = 1'b1;
  localparam logic DONE_ASSERTED  = 1'b1;
  localparam logic BUSY_ASSERTED  = 1'b1;

  // Unit is busy whenever it is not waiting for a request.
  function automatic logic state_is_busy(input state_t s);
    return (s != S_IDLE) ? BUSY_ASSERTED : ~BUSY_ASSERTED;
  endfunction

  // done is a one-cycle pulse that coincides with the DONE state.
  function automatic logic state_is_done(input state_t s);
    return (s == S_DONE) ? DONE_ASSERTED : ~DONE_ASSERTED;
  endfunction

endpackage : arith_seq_pkg

// File: rtl/seq_restoring_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One iteration of unsigned restoring division (purely combinational).
//   {R,Q} is shifted left by one, the divisor is trial-subtracted from the new
//   partial remainder, and the subtraction is kept only if it did not borrow.
//   The incoming quotient bit is 1 when the subtraction is kept.
// Ports:
//   i_r  [W:0]    partial remainder before the step
//   i_q  [W-1:0]  dividend/quotient shift register before the step
//   i_d  [W-1:0]  divisor
//   o_r  [W:0]    partial remainder after the step
//   o_q  [W-1:0]  quotient shift register after the step
// ----------------------------------------------------------------------------
module div_step #(
  parameter int unsigned W = 4
) (
  input  logic [W:0]   i_r,
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_d,
  output logic [W:0]   o_r,
  output logic [W-1:0] o_q
);

  localparam int unsigned RQ_W = 2 * W + 1;

  logic [RQ_W-1:0] w_rq;
  logic [RQ_W-1:0] w_rq_sh;
  logic [W:0]      w_r_sh;
  logic [W-1:0]    w_q_sh;
  logic [W:0]      w_trial;

  // Shift the combined {R,Q} register left by one.
  always_comb begin
    w_rq    = {i_r, i_q};
    w_rq_sh = w_rq << 1;
    w_r_sh  = w_rq_sh[RQ_W-1:W];
    w_q_sh  = w_rq_sh[W-1:0];
  end

  // Trial subtraction W+1 bits wide; the MSB acts as the borrow flag because
  // the shifted remainder is always below twice the divisor.
  always_comb begin
    w_trial = w_r_sh - {1'b0, i_d};
  end

  // Keep the difference when no borrow occurred, otherwise restore.
  always_comb begin
    o_r = w_r_sh;
    o_q = w_q_sh;
    if (!w_trial[W]) begin
      o_r = w_trial;
      o_q = w_q_sh | W'(1);
    end
  end

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Uses the same start/busy/done handshake as the shift-add multiplier.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; aborts any division in flight
//   start      request, sampled only while idle
//   dividend   numerator, latched when the request is accepted
//   divisor    denominator, latched when the request is accepted
//   busy       high while not idle
//   done       one-cycle pulse when results are valid
//   quotient   result, held until the next result is written or reset
//   remainder  result, held like quotient
//   div_by_0   flags a zero divisor; written and held with the results
// ----------------------------------------------------------------------------
module seq_restoring_divider
  import arith_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_0
);

  localparam int unsigned       CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(W - 1);

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Iteration datapath
  logic [W:0]       r_rem;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [W:0]       w_rem_nxt;
  logic [W-1:0]     w_q_nxt;

  // Registered outputs
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] r_quotient;
  logic [W-1:0] r_remainder;
  logic         r_div_by_0;

  // Decoded control
  logic w_divisor_zero;
  logic w_accept;
  logic w_load;
  logic w_load_zero;
  logic w_step;
  logic w_last;

  // One restoring iteration on the current datapath contents.
  div_step #(
    .W (W)
  ) u_div_step (
    .i_r (r_rem),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_rem_nxt),
    .o_q (w_q_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A zero divisor skips the iteration entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start == START_ASSERTED) begin
          w_state_nxt = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/control decode from the current state and inputs.
  always_comb begin
    w_divisor_zero = 1'b0;
    w_accept       = 1'b0;
    w_load         = 1'b0;
    w_load_zero    = 1'b0;
    w_step         = 1'b0;
    w_last         = 1'b0;

    w_divisor_zero = (divisor == '0);
    w_accept       = (r_state == S_IDLE) && (start == START_ASSERTED);
    w_load         = w_accept && !w_divisor_zero;
    w_load_zero    = w_accept && w_divisor_zero;
    w_step         = (r_state == S_CALC);
    w_last         = w_step && (r_cnt == LAST_CNT);
  end

  // Operand/iteration registers; operands are only sampled on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_rem <= '0;
      r_q   <= dividend;
      r_d   <= divisor;
      r_cnt <= '0;
    end else if (w_step) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers change only when a result is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_by_0  <= 1'b0;
    end else if (w_load_zero) begin
      r_quotient  <= '1;
      r_remainder <= dividend;
      r_div_by_0  <= 1'b1;
    end else if (w_last) begin
      r_quotient  <= w_q_nxt;
      r_remainder <= w_rem_nxt[W-1:0];
      r_div_by_0  <= 1'b0;
    end
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= state_is_busy(w_state_nxt);
      r_done <= state_is_done(w_state_nxt);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_by_0  = r_div_by_0;

endmodule : seq_restoring_divider
